// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM capture path: FSM state encoding and
// synchronizer depth.
package pwm_pkg;

    // State encoding, 2 bits
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HIGH    = 2'd1;
    localparam logic [1:0] ST_LOW     = 2'd2;
    localparam logic [1:0] ST_TIMEOUT = 2'd3;

    // Number of flops in the input synchronizer
    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        HIGH    = ST_HIGH,
        LOW     = ST_LOW,
        TIMEOUT = ST_TIMEOUT
    } state_e;

endpackage

// File: rtl/pwm_sync_edge.sv
// Synchronizes an asynchronous pin into the clk domain and flags its rising
// and falling edges. rise/fall are single-cycle pulses derived from the
// synchronized level and its one-cycle-delayed copy.
module pwm_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic pwm_in,
    output logic s,
    output logic rise,
    output logic fall
);
    import pwm_pkg::*;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   s_d_q;
    logic                   s_d_d;

    // Shift the pin through the synchronizer and keep a delayed copy of the output
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pwm_in};
        s_d_d  = sync_q[SYNC_STAGES-1];
    end

    // Synchronizer and delay registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            s_d_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            s_d_q  <= s_d_d;
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d_q;
    assign fall = ~s & s_d_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of a PWM input in clock cycles. A counter
// restarts on every rising edge; the falling edge snapshots the high time and
// the next rising edge publishes a coherent period/high pair. A flat input
// for 2^n-1 cycles raises stuck and records the level it was stuck at.
module pwm_capture #(
    parameter int n = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         pwm_in,
    output logic [n-1:0] period_out,
    output logic [n-1:0] high_out,
    output logic         valid,
    output logic         stuck,
    output logic         level
);
    import pwm_pkg::*;

    localparam logic [n-1:0] MAX = '1;
    localparam logic [n-1:0] ONE = {{(n-1){1'b0}}, 1'b1};

    logic s;
    logic rise;
    logic fall;
    logic timeout;

    state_e       state_q,    state_d;
    logic [n-1:0] cnt_q,      cnt_d;
    logic [n-1:0] high_tmp_q, high_tmp_d;
    logic [n-1:0] period_q,   period_d;
    logic [n-1:0] high_q,     high_d;
    logic         valid_q,    valid_d;
    logic         stuck_q,    stuck_d;
    logic         level_q,    level_d;

    pwm_sync_edge u_sync (
        .clk    (clk),
        .reset  (reset),
        .pwm_in (pwm_in),
        .s      (s),
        .rise   (rise),
        .fall   (fall)
    );

    // Next-state logic: counter, high-time snapshot, FSM and result registers.
    // An edge in the same cycle as saturation takes priority over timeout.
    always_comb begin
        state_d    = state_q;
        high_tmp_d = high_tmp_q;
        period_d   = period_q;
        high_d     = high_q;
        valid_d    = 1'b0;
        stuck_d    = stuck_q;
        level_d    = level_q;
        timeout    = (cnt_q == MAX) && !(rise || fall);

        if (rise)              cnt_d = ONE;
        else if (cnt_q == MAX) cnt_d = MAX;
        else                   cnt_d = cnt_q + ONE;

        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = HIGH;
                end else if (timeout) begin
                    state_d = TIMEOUT;
                    stuck_d = 1'b1;
                    level_d = s;
                end
            end
            HIGH: begin
                if (fall) begin
                    state_d    = LOW;
                    high_tmp_d = cnt_q;
                end else if (timeout) begin
                    state_d = TIMEOUT;
                    stuck_d = 1'b1;
                    level_d = s;
                end
            end
            LOW: begin
                if (rise) begin
                    state_d  = HIGH;
                    period_d = cnt_q;
                    high_d   = high_tmp_q;
                    valid_d  = 1'b1;
                end else if (timeout) begin
                    state_d = TIMEOUT;
                    stuck_d = 1'b1;
                    level_d = s;
                end
            end
            TIMEOUT: begin
                // Partial period after a stall is discarded; falls are ignored
                if (rise) begin
                    state_d = HIGH;
                    stuck_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, all cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            high_tmp_q <= '0;
            period_q   <= '0;
            high_q     <= '0;
            valid_q    <= 1'b0;
            stuck_q    <= 1'b0;
            level_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            high_tmp_q <= high_tmp_d;
            period_q   <= period_d;
            high_q     <= high_d;
            valid_q    <= valid_d;
            stuck_q    <= stuck_d;
            level_q    <= level_d;
        end
    end

    assign period_out = period_q;
    assign high_out   = high_q;
    assign valid      = valid_q;
    assign stuck      = stuck_q;
    assign level      = level_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture. The driver describes the waveform as a list of
// (high, low) periods; the model turns each completed period into an expected
// report (cycle, period, high) or a stall, and a monitor checks every valid.
module tb_pwm_capture;

    localparam int N   = 10;
    localparam int MAX = (1 << N) - 1;
    localparam int W   = 32 + 2 * N;

    logic         clk    = 1'b0;
    logic         reset  = 1'b1;
    logic         pwm_in = 1'b0;
    logic [N-1:0] period_out;
    logic [N-1:0] high_out;
    logic         valid;
    logic         stuck;
    logic         level;

    pwm_capture #(.n(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .pwm_in     (pwm_in),
        .period_out (period_out),
        .high_out   (high_out),
        .valid      (valid),
        .stuck      (stuck),
        .level      (level)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard state
    int           tests = 0;
    int           fails = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_e;
    int           stuck_events     = 0;
    int           exp_stuck_events = 0;
    logic         stuck_prev       = 1'b0;

    // Reference model state: the last fully driven period
    int cur_h     = 0;
    int prev_h    = 0;
    int prev_l    = 0;
    bit have_prev = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every valid must match the oldest expected report
    always @(negedge clk) begin
        if (reset && valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: got period %0d high %0d at cycle %0d expected no valid",
                         period_out, high_out, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("valid_cycle", cyc, int'(mon_e[W-1 -: 32]));
                check("period_out", int'(period_out), int'(mon_e[2*N-1 -: N]));
                check("high_out", int'(high_out), int'(mon_e[N-1:0]));
            end
        end
        if (stuck && !stuck_prev) stuck_events++;
        stuck_prev = stuck;
    end

    // Driver tasks: entered at a negedge, leave at a negedge.
    // A rise completes the previous period: report it if it fit in MAX cycles.
    task automatic begin_high(input int h);
        if (have_prev && (prev_h + prev_l <= MAX))
            exp_q.push_back({32'(cyc + 3), N'(prev_h + prev_l), N'(prev_h)});
        cur_h  = h;
        pwm_in = 1'b1;
        repeat (h) @(negedge clk);
    endtask

    task automatic end_low(input int l);
        pwm_in = 1'b0;
        repeat (l) @(negedge clk);
        prev_h    = cur_h;
        prev_l    = l;
        have_prev = 1'b1;
        if (cur_h + l > MAX) exp_stuck_events++;
    endtask

    task automatic drive_period(input int h, input int l);
        begin_high(h);
        end_low(l);
    endtask

    // Close out the pending period with a short 4/4 period and check the books
    task automatic checkpoint(input string name);
        begin_high(4);
        check({name, "_pending"}, exp_q.size(), 0);
        check({name, "_stuck_events"}, stuck_events, exp_stuck_events);
        end_low(4);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_period"}, int'(period_out), 0);
        check({name, "_high"}, int'(high_out), 0);
        check({name, "_valid"}, int'(valid), 0);
        check({name, "_stuck"}, int'(stuck), 0);
        check({name, "_level"}, int'(level), 0);
    endtask

    initial begin
        // Reset state
        #2 reset = 1'b0;
        #1 check_outputs_zero("reset");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // 3 high / 7 low
        for (int i = 0; i < 6; i++) drive_period(3, 7);
        checkpoint("p3_7");

        // Random periods
        for (int i = 0; i < 40; i++)
            drive_period(int'($urandom_range(1, 20)), int'($urandom_range(1, 30)));
        checkpoint("random");

        // Minimum decodable waveform
        for (int i = 0; i < 20; i++) drive_period(1, 1);
        checkpoint("min");

        // Longest measurable period
        for (int i = 0; i < 3; i++) drive_period(1, MAX - 1);
        check("b1022_stuck", int'(stuck), 0);
        checkpoint("b1022");

        // One cycle too long: stall each period, no report
        for (int i = 0; i < 3; i++) drive_period(1, MAX);
        checkpoint("b1023");

        // Reset during the low phase of a 5/15 waveform
        for (int i = 0; i < 2; i++) drive_period(5, 15);
        begin_high(5);
        pwm_in = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b0;
        #1 check_outputs_zero("mid_reset");
        repeat (3) @(negedge clk);
        reset     = 1'b1;
        have_prev = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 3; i++) drive_period(5, 15);
        checkpoint("reset_5_15");

        // Flat low after reset
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset     = 1'b1;
        have_prev = 1'b0;
        pwm_in    = 1'b0;
        repeat (1030) @(negedge clk);
        check("flat0_stuck", int'(stuck), 1);
        check("flat0_level", int'(level), 0);
        exp_stuck_events++;
        repeat (70) @(negedge clk);
        check("flat0_stuck_events", stuck_events, exp_stuck_events);

        // Flat high, then 4 low / 6 high / 4 low
        begin_high(1100);
        check("flat1_stuck", int'(stuck), 1);
        check("flat1_level", int'(level), 1);
        end_low(4);
        check("flat1_fall_ignored", int'(stuck), 1);
        begin_high(6);
        check("flat1_cleared", int'(stuck), 0);
        end_low(4);
        checkpoint("stuck_high");

        // Drain
        pwm_in = 1'b0;
        repeat (10) @(negedge clk);
        check("final_pending", exp_q.size(), 0);
        check("final_stuck_events", stuck_events, exp_stuck_events);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
